gate_window_sequencer: RTL and testbench
========================================

// Module: gate_window_sequencer
// PURPOSE
//  Turns an asynchronous external gate into a timed acquisition window plus a readout request.
//  Synchronises the gate and detects its rising and falling edges.
//  On a rising edge it waits a programmable delay, opens window_open for a programmable width,
//  then raises rd_req and holds it until the downstream readout engine returns rd_ack.
//  Sits between the ROC gate input pin and the per-channel readout/DDR write logic.
// PARAMETERS
//  DLY_W  16  width of cfg_delay (delay in clk cycles)
//  WID_W  16  width of cfg_width (window length in clk cycles)
//  CNT_W  16  width of win_count / miss_count
// PORTS
//  clk          in   1      system clock
//  resetn       in   1      reset, asynchronous, active-low
//  gate         in   1      external gate, asynchronous to clk
//  enable       in   1      arm sequencer; sampled only in IDLE
//  cfg_delay    in   DLY_W  rise-to-window delay, cycles; captured on accepted rise
//  cfg_width    in   WID_W  window length, cycles; captured on accepted rise; 0 treated as 1
//  cfg_abort    in   1      1 = falling gate edge aborts/truncates; captured on accepted rise
//  rd_ack       in   1      readout done; honoured only while rd_req=1
//  window_open  out  1      registered, high exactly while FSM in OPEN
//  rd_req       out  1      registered, high exactly while FSM in READOUT
//  busy         out  1      registered, high whenever FSM not IDLE
//  win_count    out  CNT_W  windows opened, wraps modulo 2^CNT_W
//  miss_count   out  CNT_W  rises ignored while busy, saturates at all-ones
//  abort_flag   out  1      sticky; set when a DELAY is aborted; cleared on next accepted rise
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, counters and sync flops 0; mid-operation reset drops everything at once.
//  Sync: gate -> 3 flops -> registered edge compare; rise_p/fall_p each one-cycle pulse.
//   rise_p is high in the cycle after the 4th clk edge at which gate is sampled high.
//  FSM states: IDLE, DELAY, OPEN, READOUT (encodings in shared include).
//  IDLE:   rise_p & enable -> capture cfg; cfg_delay==0 ? OPEN : DELAY (next cycle).
//          rise_p & !enable -> ignored, not counted.
//  DELAY:  lasts exactly cfg_delay cycles, then OPEN.
//          fall_p & cfg_abort -> IDLE; no window, no rd_req; abort_flag<=1.
//  OPEN:   lasts exactly max(cfg_width,1) cycles, then READOUT.
//          win_count increments on the entry cycle.
//          fall_p & cfg_abort -> READOUT next cycle (truncated window).
//  READOUT: rd_req=1; rd_ack=1 sampled -> IDLE next cycle. No timeout.
//  rise_p in any non-IDLE state: miss_count++ (saturating); sequence is not restarted.
//  Same-cycle fall_p and counter expiry in DELAY/OPEN: fall_p has priority.
//  rd_ack outside READOUT is ignored. enable deassert mid-sequence: current sequence completes.
//  Latency: gate rise to window_open=1 is 4 + cfg_delay + 1 cycles.
// STRUCTURE
//  Shared include gate_seq_defs.vh: FSM state encodings (2-bit) and the default widths.
//  Sub-module gate_sync_edge (3-flop synchroniser plus rise/fall pulse).
//  Top level holds the FSM, the delay/width down-counter (max(DLY_W,WID_W) bits), the config
//  capture registers and the status counters.
// TESTING
//  1 delay=3,width=5,abort=0; gate 0->1 held 20 cyc; ack 2 cyc after req -> window_open high
//    exactly 5 cyc starting 8 cyc after rise; rd_req held until ack; win_count=1; busy then 0.
//  2 delay=0,width=0 -> window_open high exactly 1 cyc, 5 cyc after rise; rd_req follows next cycle.
//  3 abort=1,delay=10; gate pulse 4 cyc wide -> no window_open, no rd_req; abort_flag=1;
//    FSM IDLE; win_count unchanged.
//  4 abort=1,delay=2,width=50; gate falls 10 cyc into window -> window truncated; rd_req next cycle;
//    win_count +1.
//  5 gate toggled 3 times while rd_req held without ack -> miss_count=3; one rd_req only;
//    saturation check with CNT_W=2 after 5 misses -> 3.
//  6 assert resetn=0 during OPEN -> all outputs 0 immediately; after release, gate already high
//    gives no rise; enable=0 with rise -> no window, miss_count unchanged.

Source files
------------

// File: rtl/gate_window_sequencer_pkg.sv
// Shared types and defaults for the gate window sequencer.
package gate_window_sequencer_pkg;

   localparam int unsigned DefDlyW = 16;
   localparam int unsigned DefWidW = 16;
   localparam int unsigned DefCntW = 16;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StDelay   = 2'd1,
      StOpen    = 2'd2,
      StReadout = 2'd3
   } state_e;

   function automatic int unsigned max_w(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/gate_window_sequencer_sync_edge.sv
// Three-flop synchroniser for the external gate plus registered rise/fall pulses.
module gate_window_sequencer_sync_edge (
   input  logic clk,
   input  logic resetn,
   input  logic gate,
   output logic rise_p,
   output logic fall_p
);

   logic [2:0] sync_q;
   logic       last_q;
   // Fills with ones after reset; edges are only reported once the whole chain and the
   // compare flop hold real samples, so a gate already high at reset release is no rise.
   logic [3:0] prime_q;

   // Synchroniser chain and edge compare.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync_q  <= '0;
         last_q  <= 1'b0;
         prime_q <= '0;
         rise_p  <= 1'b0;
         fall_p  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[1:0], gate};
         prime_q <= {prime_q[2:0], 1'b1};
         last_q  <= sync_q[2];
         rise_p  <= prime_q[3] & sync_q[2] & ~last_q;
         fall_p  <= prime_q[3] & ~sync_q[2] & last_q;
      end
   end

endmodule

// File: rtl/gate_window_sequencer.sv
// Gate-triggered acquisition window sequencer: delay, window, then readout handshake.
module gate_window_sequencer
   import gate_window_sequencer_pkg::*;
#(
   parameter int unsigned DLY_W = DefDlyW,
   parameter int unsigned WID_W = DefWidW,
   parameter int unsigned CNT_W = DefCntW
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             gate,
   input  logic             enable,
   input  logic [DLY_W-1:0] cfg_delay,
   input  logic [WID_W-1:0] cfg_width,
   input  logic             cfg_abort,
   input  logic             rd_ack,
   output logic             window_open,
   output logic             rd_req,
   output logic             busy,
   output logic [CNT_W-1:0] win_count,
   output logic [CNT_W-1:0] miss_count,
   output logic             abort_flag
);

   localparam int unsigned CTR_W = max_w(DLY_W, WID_W);

   logic             rise_p;
   logic             fall_p;
   state_e           state_q;
   logic [CTR_W-1:0] ctr_q;
   logic [WID_W-1:0] width_q;
   logic             abort_q;

   // Counter reload values: the counter runs N-1 .. 0, and a zero width means one cycle.
   logic [CTR_W-1:0] dly_load;
   logic [CTR_W-1:0] wid_in_load;
   logic [CTR_W-1:0] wid_q_load;

   assign dly_load    = CTR_W'(cfg_delay) - CTR_W'(1);
   assign wid_in_load = (cfg_width == '0) ? '0 : CTR_W'(cfg_width) - CTR_W'(1);
   assign wid_q_load  = (width_q == '0) ? '0 : CTR_W'(width_q) - CTR_W'(1);

   gate_window_sequencer_sync_edge u_sync (
      .clk    (clk),
      .resetn (resetn),
      .gate   (gate),
      .rise_p (rise_p),
      .fall_p (fall_p)
   );

   // Sequencer FSM with registered outputs, config capture and status counters.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= StIdle;
         ctr_q       <= '0;
         width_q     <= '0;
         abort_q     <= 1'b0;
         window_open <= 1'b0;
         rd_req      <= 1'b0;
         busy        <= 1'b0;
         win_count   <= '0;
         miss_count  <= '0;
         abort_flag  <= 1'b0;
      end else begin
         if (rise_p && (state_q != StIdle) && (miss_count != '1)) begin
            miss_count <= miss_count + CNT_W'(1);
         end
         case (state_q)
            StIdle: begin
               if (rise_p && enable) begin
                  width_q    <= cfg_width;
                  abort_q    <= cfg_abort;
                  abort_flag <= 1'b0;
                  busy       <= 1'b1;
                  if (cfg_delay == '0) begin
                     state_q     <= StOpen;
                     ctr_q       <= wid_in_load;
                     window_open <= 1'b1;
                     win_count   <= win_count + CNT_W'(1);
                  end else begin
                     state_q <= StDelay;
                     ctr_q   <= dly_load;
                  end
               end
            end
            StDelay: begin
               // A qualifying fall wins over expiry in the same cycle.
               if (fall_p && abort_q) begin
                  state_q    <= StIdle;
                  busy       <= 1'b0;
                  abort_flag <= 1'b1;
               end else if (ctr_q == '0) begin
                  state_q     <= StOpen;
                  ctr_q       <= wid_q_load;
                  window_open <= 1'b1;
                  win_count   <= win_count + CNT_W'(1);
               end else begin
                  ctr_q <= ctr_q - CTR_W'(1);
               end
            end
            StOpen: begin
               if ((fall_p && abort_q) || (ctr_q == '0)) begin
                  state_q     <= StReadout;
                  window_open <= 1'b0;
                  rd_req      <= 1'b1;
               end else begin
                  ctr_q <= ctr_q - CTR_W'(1);
               end
            end
            StReadout: begin
               if (rd_ack) begin
                  state_q <= StIdle;
                  rd_req  <= 1'b0;
                  busy    <= 1'b0;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gate_window_sequencer.sv
// Directed bench for gate_window_sequencer with a window-timing scoreboard.
module tb_gate_window_sequencer;

   logic        clk = 1'b0;
   logic        resetn;
   logic        gate;
   logic        enable;
   logic [15:0] cfg_delay;
   logic [15:0] cfg_width;
   logic        cfg_abort;
   logic        rd_ack;

   logic        window_open, rd_req, busy, abort_flag;
   logic [15:0] win_count, miss_count;
   logic        s_window_open, s_rd_req, s_busy, s_abort_flag;
   logic [1:0]  s_win_count, s_miss_count;

   int checks = 0;
   int failures = 0;

   typedef struct {
      string tag;
      int    lat;
      int    wid;
      int    drop_after;
   } exp_t;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   gate_window_sequencer dut (
      .clk         (clk),
      .resetn      (resetn),
      .gate        (gate),
      .enable      (enable),
      .cfg_delay   (cfg_delay),
      .cfg_width   (cfg_width),
      .cfg_abort   (cfg_abort),
      .rd_ack      (rd_ack),
      .window_open (window_open),
      .rd_req      (rd_req),
      .busy        (busy),
      .win_count   (win_count),
      .miss_count  (miss_count),
      .abort_flag  (abort_flag)
   );

   gate_window_sequencer #(.CNT_W(2)) dut_sat (
      .clk         (clk),
      .resetn      (resetn),
      .gate        (gate),
      .enable      (enable),
      .cfg_delay   (cfg_delay),
      .cfg_width   (cfg_width),
      .cfg_abort   (cfg_abort),
      .rd_ack      (rd_ack),
      .window_open (s_window_open),
      .rd_req      (s_rd_req),
      .busy        (s_busy),
      .win_count   (s_win_count),
      .miss_count  (s_miss_count),
      .abort_flag  (s_abort_flag)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Cycles from the gate change to the first sample with window_open high (bounded).
   task automatic wait_open(output int lat);
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!window_open && lat < 200);
   endtask

   // Length of the window in cycles; optionally drops gate after the n-th high sample.
   task automatic count_open(input int drop_after, output int wid);
      wid = 1;
      forever begin
         if (wid == drop_after) gate = 1'b0;
         tick();
         if (!window_open || wid >= 200) break;
         wid++;
      end
   endtask

   task automatic raise_gate(input string tag, input int lat, input int wid, input int drop);
      exp_t e;
      e.tag = tag;
      e.lat = lat;
      e.wid = wid;
      e.drop_after = drop;
      exp_q.push_back(e);
      gate = 1'b1;
   endtask

   task automatic measure_window();
      exp_t e;
      int   lat;
      int   wid;
      if (exp_q.size() == 0) begin
         check("scoreboard_empty", 1, 0);
         return;
      end
      e = exp_q.pop_front();
      wait_open(lat);
      check({e.tag, "_latency"}, lat, e.lat);
      check({e.tag, "_busy_in_window"}, busy, 1);
      count_open(e.drop_after, wid);
      check({e.tag, "_width"}, wid, e.wid);
      check({e.tag, "_rd_req_after_window"}, rd_req, 1);
   endtask

   task automatic ack_readout(input string tag);
      rd_ack = 1'b1;
      tick();
      rd_ack = 1'b0;
      check({tag, "_rd_req_cleared"}, rd_req, 0);
      check({tag, "_busy_cleared"}, busy, 0);
   endtask

   initial begin
      int seen_win;
      int seen_req;
      int seen_busy;
      int req_dropped;

      resetn    = 1'b0;
      gate      = 1'b0;
      enable    = 1'b0;
      cfg_delay = '0;
      cfg_width = '0;
      cfg_abort = 1'b0;
      rd_ack    = 1'b0;
      ticks(3);
      check("reset_window_open", window_open, 0);
      check("reset_rd_req", rd_req, 0);
      check("reset_busy", busy, 0);
      check("reset_win_count", win_count, 0);
      check("reset_miss_count", miss_count, 0);
      check("reset_abort_flag", abort_flag, 0);
      resetn = 1'b1;
      ticks(6);

      // 1: delay 3, width 5, no abort, ack two cycles after request
      enable    = 1'b1;
      cfg_delay = 16'd3;
      cfg_width = 16'd5;
      cfg_abort = 1'b0;
      raise_gate("t1", 8, 5, 0);
      measure_window();
      check("t1_win_count", win_count, 1);
      tick();
      check("t1_rd_req_hold1", rd_req, 1);
      tick();
      check("t1_rd_req_hold2", rd_req, 1);
      ack_readout("t1");
      ticks(5);
      gate = 1'b0;
      ticks(6);

      // 2: zero delay and zero width give a single-cycle window
      cfg_delay = 16'd0;
      cfg_width = 16'd0;
      raise_gate("t2", 5, 1, 0);
      measure_window();
      check("t2_win_count", win_count, 2);
      ack_readout("t2");
      gate = 1'b0;
      ticks(6);

      // 3: short gate pulse aborts the delay phase
      cfg_delay = 16'd10;
      cfg_width = 16'd5;
      cfg_abort = 1'b1;
      gate = 1'b1;
      ticks(4);
      gate = 1'b0;
      seen_win = 0;
      seen_req = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (window_open) seen_win++;
         if (rd_req) seen_req++;
      end
      check("t3_no_window", seen_win, 0);
      check("t3_no_rd_req", seen_req, 0);
      check("t3_abort_flag", abort_flag, 1);
      check("t3_idle", busy, 0);
      check("t3_win_count", win_count, 2);

      // 4: falling gate truncates an open window
      cfg_delay = 16'd2;
      cfg_width = 16'd50;
      cfg_abort = 1'b1;
      raise_gate("t4", 7, 10, 6);
      measure_window();
      check("t4_win_count", win_count, 3);
      check("t4_abort_flag_cleared", abort_flag, 0);
      ack_readout("t4");
      ticks(6);

      // 5: rises while waiting for ack are counted as misses, saturating on the narrow copy
      cfg_delay = 16'd0;
      cfg_width = 16'd2;
      cfg_abort = 1'b0;
      raise_gate("t5", 5, 2, 0);
      measure_window();
      req_dropped = 0;
      for (int t = 0; t < 5; t++) begin
         gate = 1'b0;
         for (int i = 0; i < 6; i++) begin
            tick();
            if (!rd_req) req_dropped++;
         end
         gate = 1'b1;
         for (int i = 0; i < 6; i++) begin
            tick();
            if (!rd_req) req_dropped++;
         end
         if (t == 2) begin
            check("t5_miss_after3", miss_count, 3);
            check("t5_sat_miss_after3", s_miss_count, 3);
         end
      end
      check("t5_miss_after5", miss_count, 5);
      check("t5_sat_miss_after5", s_miss_count, 3);
      check("t5_rd_req_never_dropped", req_dropped, 0);
      check("t5_single_window", win_count, 4);
      check("t5_sat_win_wrap", s_win_count, 0);
      ack_readout("t5");
      gate = 1'b0;
      ticks(6);

      // 6: reset during an open window, then gate high at release and a disabled rise
      cfg_delay = 16'd0;
      cfg_width = 16'd20;
      gate = 1'b1;
      begin
         int lat;
         wait_open(lat);
         check("t6_latency", lat, 5);
      end
      ticks(2);
      resetn = 1'b0;
      #1;
      check("t6_rst_window_open", window_open, 0);
      check("t6_rst_rd_req", rd_req, 0);
      check("t6_rst_busy", busy, 0);
      check("t6_rst_win_count", win_count, 0);
      check("t6_rst_miss_count", miss_count, 0);
      check("t6_rst_abort_flag", abort_flag, 0);
      tick();
      resetn = 1'b1;
      seen_busy = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (busy || window_open) seen_busy++;
      end
      check("t6_no_rise_at_release", seen_busy, 0);
      gate = 1'b0;
      ticks(8);
      enable = 1'b0;
      gate = 1'b1;
      seen_busy = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (busy || window_open) seen_busy++;
      end
      check("t6_disabled_no_window", seen_busy, 0);
      check("t6_disabled_miss_count", miss_count, 0);
      check("t6_disabled_win_count", win_count, 0);
      check("scoreboard_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
